// File: rtl/uart_tx_pkg.sv
// Shared definitions for the uart_tx transmitter: frame shape, FSM encoding,
// FIFO entry layout and the small elaboration-time helpers.
package uart_tx_pkg;

   // Frame shape: one start bit, eight data bits (LSB first), stop bit(s).
   localparam int DATA_BITS  = 8;
   localparam int STOP_BITS  = 1;
   localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

   // Transmit FSM states.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_GAP   = 3'd4
   } tx_state_e;

   // One queued byte plus its end-of-packet marker.
   typedef struct packed {
      logic                 last;
      logic [DATA_BITS-1:0] data;
   } tx_entry_t;

   // Clocks spent on each bit; integer division, the line is timed from this.
   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   // Width of a counter that has to hold 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the transmitter. Pointers carry one extra
// wrap bit so full and empty are told apart without an occupancy counter.
module uart_tx_fifo
   import uart_tx_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic      clk,
   input  logic      rst,
   input  logic      wr_valid,
   input  tx_entry_t wr_entry,
   output logic      wr_ready,
   input  logic      rd_en,
   output tx_entry_t rd_entry,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   tx_entry_t   mem_q [DEPTH];
   tx_entry_t   mem_d [DEPTH];
   logic        full;
   logic        wr_en;
   logic        rd_do;

   // Full when the wrap bits differ and the index bits match.
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty    = (wr_ptr_q == rd_ptr_q);
   // Writes offered while full are simply not taken.
   assign wr_ready = ~full & ~rst;
   assign wr_en    = wr_valid & wr_ready;
   assign rd_do    = rd_en & ~empty;
   assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

   // Next pointer values and storage contents.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (wr_en) begin
         mem_d[wr_ptr_q[AW-1:0]] = wr_entry;
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (rd_do) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   // Pointer registers; reset flushes the queue.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small input FIFO and an optional idle gap after
// packet-closing bytes so the far receiver can detect end-of-packet.
// Valid/ready: a byte (with its last flag) is taken on the rising clk edge where
// tx_valid and tx_ready are both high; tx_ready never depends on tx_valid.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int clk_freq   = 15360000,
   parameter int baud       = 614400,
   parameter int fifo_depth = 4,
   parameter int gap_bits   = 4
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_idle
);

   localparam int CPB   = clks_per_bit(clk_freq, baud);
   localparam int DIV_W = cnt_width(CPB);
   localparam int GAP_W = cnt_width(gap_bits);

   tx_entry_t            wr_entry;
   tx_entry_t            rd_entry;
   logic                 fifo_empty;
   logic                 pop;

   tx_state_e            state_q, state_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 last_q, last_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 idle_q, idle_d;
   logic                 bit_done;

   assign wr_entry = '{last: tx_last, data: tx_data};

   uart_tx_fifo #(
      .DEPTH (fifo_depth)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_valid (tx_valid),
      .wr_entry (wr_entry),
      .wr_ready (tx_ready),
      .rd_en    (pop),
      .rd_entry (rd_entry),
      .empty    (fifo_empty)
   );

   // Last clock of the current bit-time.
   assign bit_done = (div_q == DIV_W'(CPB - 1));

   // FSM next state, bit-time divider, counters and the line value.
   // The line and status outputs are registered from the current state, so
   // they trail the state by one clock; every segment keeps its full length.
   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      shift_d   = shift_q;
      last_d    = last_q;
      pop       = 1'b0;

      if (state_q != ST_IDLE) begin
         div_d = bit_done ? '0 : div_q + DIV_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            div_d = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = rd_entry.data;
               last_d  = rd_entry.last;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (bit_done) begin
               state_d   = ST_DATA;
               bit_cnt_d = '0;
            end
         end
         ST_DATA: begin
            if (bit_done) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                  state_d   = ST_STOP;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         ST_STOP: begin
            if (bit_done) begin
               if (bit_cnt_q != 3'(STOP_BITS - 1)) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end else if (last_q) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = '0;
               end else if (!fifo_empty) begin
                  // Next start bit follows the stop bit with no idle clock.
                  pop     = 1'b1;
                  shift_d = rd_entry.data;
                  last_d  = rd_entry.last;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (bit_done) begin
               if (gap_cnt_q != GAP_W'(gap_bits - 1)) begin
                  gap_cnt_d = gap_cnt_q + GAP_W'(1);
               end else if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = rd_entry.data;
                  last_d  = rd_entry.last;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      case (state_q)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_q[0];
         default:  tx_d = 1'b1;
      endcase

      busy_d = (state_q != ST_IDLE);
      idle_d = (state_q == ST_IDLE) & fifo_empty;
   end

   // FSM and output registers; reset abandons any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         div_q     <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         shift_q   <= '0;
         last_q    <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         idle_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         shift_q   <= shift_d;
         last_q    <= last_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         idle_q    <= idle_d;
      end
   end

   assign tx      = tx_q;
   assign tx_busy = busy_q;
   assign tx_idle = idle_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-schedule model predicts the line, busy, ready and
// idle outputs cycle by cycle; directed scenarios add hand-computed pins.
module tb_uart_tx;

   localparam int CPB      = 25;
   localparam int FRAME    = 10 * CPB;
   localparam int GAP_CLKS = 4 * CPB;
   localparam int DEPTH    = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_last = 1'b0;
   logic       tx_ready;
   logic       tx;
   logic       tx_busy;
   logic       tx_idle;

   uart_tx #(
      .clk_freq   (15360000),
      .baud       (614400),
      .fifo_depth (DEPTH),
      .gap_bits   (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_last  (tx_last),
      .tx_ready (tx_ready),
      .tx       (tx),
      .tx_busy  (tx_busy),
      .tx_idle  (tx_idle)
   );

   // Clock and cycle counter (cyc = number of rising edges seen).
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
      end
   endtask

   // Scoreboard: one record per accepted byte, with its scheduled line timing.
   int         fr_acc[$];
   int         fr_start[$];
   int         fr_end[$];
   logic [7:0] fr_data[$];
   int         head = 0;
   int         line_free = 0;
   bit         mon_en = 0;
   bit         acc_now = 0;
   bit         m_quiet = 1;

   // Model and compare, once per cycle away from the rising edge.
   always @(negedge clk) begin : model
      int n, occ, s, b, acc, st;
      logic e_tx, e_busy, e_ready;
      if (mon_en) begin
         n = cyc;
         while (head < fr_start.size() && fr_end[head] <= n) head++;
         e_tx = 1'b1;
         e_busy = 1'b0;
         occ = 0;
         for (int i = head; i < fr_start.size(); i++) begin
            s = fr_start[i];
            if (n >= s && n < s + FRAME) begin
               b = (n - s) / CPB;
               if (b == 0) e_tx = 1'b0;
               else if (b <= 8) e_tx = fr_data[i][b-1];
            end
            if (n >= s && n < fr_end[i]) e_busy = 1'b1;
            // Queued in the FIFO: written by now, not yet taken by the FSM.
            if (fr_acc[i] <= n && s - 1 > n) occ++;
         end
         e_ready = !rst && (occ < DEPTH);
         m_quiet = (head == fr_start.size() || fr_acc[head] > n) && (line_free <= n);
         check("tx_line", tx, e_tx);
         check("tx_busy", tx_busy, e_busy);
         check("tx_ready", tx_ready, e_ready);
         if (e_busy) check("tx_idle_busy", tx_idle, 0);
         else if (m_quiet) check("tx_idle_quiet", tx_idle, 1);
         acc_now = 0;
         if (tx_valid && e_ready) begin
            acc = n + 1;
            st = (acc + 2 > line_free) ? acc + 2 : line_free;
            fr_acc.push_back(acc);
            fr_start.push_back(st);
            fr_data.push_back(tx_data);
            line_free = st + FRAME + (tx_last ? GAP_CLKS : 0);
            fr_end.push_back(line_free);
            acc_now = 1;
         end
         if (rst) begin
            head = fr_start.size();
            line_free = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) step();
   endtask

   // Offer one byte until it is taken; returns the accepting edge number.
   task automatic send(input logic [7:0] d, input logic l, output int acc_edge);
      int budget = 2000;
      tx_data  = d;
      tx_last  = l;
      tx_valid = 1'b1;
      do begin
         step();
         budget--;
      end while (!acc_now && budget > 0);
      check("send_accepted", acc_now, 1);
      acc_edge = cyc;
      tx_valid = 1'b0;
      tx_last  = 1'b0;
   endtask

   task automatic drain();
      int budget = 5000;
      step();
      step();
      while (!m_quiet && budget > 0) begin
         step();
         budget--;
      end
      check("drain_done", m_quiet, 1);
      check("drain_idle", tx_idle, 1);
   endtask

   logic [7:0] t4_bytes [6];
   int a, b2;

   initial begin
      t4_bytes = '{8'hC1, 8'h2D, 8'h96, 8'h4B, 8'hE7, 8'h08};

      // Reset behaviour.
      rst = 1'b1;
      step();
      mon_en = 1;
      check("rst_tx", tx, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_idle", tx_idle, 1);
      check("rst_ready", tx_ready, 0);
      step();
      rst = 1'b0;
      #1;
      check("rst_ready_after", tx_ready, 1);
      step();

      // Single 0x55 frame: 2-clock latency, 25-clock bits, 250 busy clocks.
      send(8'h55, 1'b0, a);
      wait_until(a + 1);   check("t1_pre_start", tx, 1);
      check("t1_pre_busy", tx_busy, 0);
      wait_until(a + 2);   check("t1_start", tx, 0);
      check("t1_busy_on", tx_busy, 1);
      wait_until(a + 26);  check("t1_start_end", tx, 0);
      wait_until(a + 27);  check("t1_bit0", tx, 1);
      wait_until(a + 52);  check("t1_bit1", tx, 0);
      wait_until(a + 227); check("t1_stop", tx, 1);
      wait_until(a + 251); check("t1_busy_last", tx_busy, 1);
      wait_until(a + 252); check("t1_busy_off", tx_busy, 0);
      drain();

      // Back-to-back 0xA5, 0x3C: second start directly after first stop.
      send(8'hA5, 1'b0, a);
      send(8'h3C, 1'b0, b2);
      wait_until(a + 251); check("t2_stop1", tx, 1);
      wait_until(a + 252); check("t2_start2", tx, 0);
      check("t2_busy_cont", tx_busy, 1);
      wait_until(a + 277); check("t2_b2_bit0", tx, 0);
      wait_until(a + 327); check("t2_b2_bit2", tx, 1);
      drain();

      // Packet end: 0x12 with last, then 0x34 after a 100-clock gap.
      send(8'h12, 1'b1, a);
      send(8'h34, 1'b0, b2);
      wait_until(a + 252); check("t3_gap_begin", tx, 1);
      wait_until(a + 351); check("t3_gap_end", tx, 1);
      check("t3_gap_busy", tx_busy, 1);
      wait_until(a + 352); check("t3_second_start", tx, 0);
      drain();

      // FIFO fill: ready drops after the fifth consecutive accept.
      for (int i = 0; i < 6; i++) begin
         send(t4_bytes[i], 1'b0, a);
         if (i == 4) check("t4_ready_full", tx_ready, 0);
      end
      drain();

      // Reset during bit3 of 0xFF with two more bytes queued.
      send(8'hFF, 1'b0, a);
      send(8'h81, 1'b0, b2);
      send(8'h7E, 1'b0, b2);
      wait_until(a + 2 + 4 * CPB + 10);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check("t5_tx_high", tx, 1);
      check("t5_idle", tx_idle, 1);
      check("t5_busy", tx_busy, 0);
      check("t5_ready", tx_ready, 1);
      repeat (600) step();
      check("t5_never_sent", tx, 1);
      check("t5_still_idle", tx_idle, 1);

      // Random traffic with bubbles and occasional packet ends.
      for (int i = 0; i < 256; i++) begin
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 30)) step();
         send(8'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0), a);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
